omem_write_sequencer: RTL and testbench

Sequences and arbitrates 96-bit output-memory writes from up to NUM_REQ requesters onto the single 32-bit Wishbone write port. Each granted request becomes a locked three-beat write burst. The burst sends the high word first, with address and data words paired beat-by-beat, and waits for ACK_I on every beat. The block sits between the execution units' output-write paths and the external Wishbone memory bus. It replaces direct, unarbitrated drive of the output-memory port.

---
 rtl/omem_write_sequencer_pkg.sv | 38 +++
 rtl/omem_write_sequencer_rr_arbiter.sv | 39 +++
 rtl/omem_write_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_omem_write_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/omem_write_sequencer_pkg.sv
// Shared definitions for the output-memory write sequencer: widths, FSM encodings,
// beat one-hot constants and the beat shift / word-select helpers.
`ifndef DATA_ROW_WIDTH
`define DATA_ROW_WIDTH 96
`endif
`ifndef WB_WIDTH
`define WB_WIDTH 32
`endif

package omem_write_sequencer_pkg;

    localparam int ROW_W = `DATA_ROW_WIDTH;
    localparam int WB_W  = `WB_WIDTH;

    typedef enum logic [1:0] {
        OMEMSEQ_IDLE   = 2'd0,
        OMEMSEQ_BEAT   = 2'd1,
        OMEMSEQ_RETIRE = 2'd2
    } omemseq_state_t;

    localparam logic [2:0] BEAT_HI  = 3'b001;
    localparam logic [2:0] BEAT_MID = 3'b010;
    localparam logic [2:0] BEAT_LO  = 3'b100;

    // Circular shift-left of the walking-one beat register.
    function automatic logic [2:0] beat_shift(input logic [2:0] beat);
        return {beat[1:0], beat[2]};
    endfunction

    // Walking-one 3-select mux: bit 0 picks the high word, bit 2 the low word.
    function automatic logic [WB_W-1:0] word_mux3(input logic [2:0] sel,
                                                  input logic [ROW_W-1:0] row);
        return ({WB_W{sel[0]}} & row[3*WB_W-1:2*WB_W]) |
               ({WB_W{sel[1]}} & row[2*WB_W-1:WB_W])   |
               ({WB_W{sel[2]}} & row[WB_W-1:0]);
    endfunction

endpackage

// File: rtl/omem_write_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps, the first
// requesting index wins.
module omem_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] cand_idx [NUM_REQ];

    // cand_idx[n] is the requester examined n places after the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_idx[gi] = IDX_W'((int'(ptr) + gi) % NUM_REQ);
    end

    always_comb begin
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                grant_idx = cand_idx[i];
            end
        end
    end

    assign grant_valid = |req;

    always_comb begin
        grant = '0;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/omem_write_sequencer.sv
// Arbitrates 96-bit output-memory writes onto a 32-bit Wishbone port as locked
// three-beat bursts, high word first, with a per-beat acknowledge timeout.
module omem_write_sequencer
    import omem_write_sequencer_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       iRequest,
    input  logic [NUM_REQ*ROW_W-1:0] iData,
    input  logic [NUM_REQ*ROW_W-1:0] iAddress,
    output logic [NUM_REQ-1:0]       oAccept,
    output logic [NUM_REQ-1:0]       oDone,
    output logic [NUM_REQ-1:0]       oError,
    output logic                     oIdle,
    output logic [WB_W-1:0]          ADR_O,
    output logic [WB_W-1:0]          DAT_O,
    output logic                     WE_O,
    output logic                     STB_O,
    output logic                     CYC_O,
    input  logic                     ACK_I
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    omemseq_state_t     state_reg, state_next;
    logic [2:0]         beat_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               err_reg;
    logic               first_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [ROW_W-1:0]   addr_hold_reg;
    logic [ROW_W-1:0]   data_hold_reg;
    logic [WB_W-1:0]    adr_reg;
    logic [WB_W-1:0]    dat_reg;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [ROW_W-1:0]   sel_data;
    logic [ROW_W-1:0]   sel_addr;
    logic               timeout_hit;
    logic [2:0]         beat_next;

    omem_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req         (iRequest),
        .ptr         (ptr_reg),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // AND-OR select of the winning requester's row, driven by the one-hot grant.
    always_comb begin
        sel_data = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = sel_data | iData[i*ROW_W +: ROW_W];
                sel_addr = sel_addr | iAddress[i*ROW_W +: ROW_W];
            end
        end
    end

    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_reg == CNT_LAST);
    assign beat_next   = beat_shift(beat_reg);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg <= OMEMSEQ_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            OMEMSEQ_IDLE: begin
                if (grant_valid) begin
                    state_next = OMEMSEQ_BEAT;
                end
            end
            OMEMSEQ_BEAT: begin
                if (ACK_I) begin
                    if (beat_reg == BEAT_LO) begin
                        state_next = OMEMSEQ_RETIRE;
                    end
                end else if (timeout_hit) begin
                    state_next = OMEMSEQ_RETIRE;
                end
            end
            OMEMSEQ_RETIRE: state_next = OMEMSEQ_IDLE;
            default:        state_next = OMEMSEQ_IDLE;
        endcase
    end

    // Burst datapath: holding registers, beat walker, ACK timeout counter, bus words.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            beat_reg      <= BEAT_HI;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
            first_reg     <= 1'b0;
            idx_reg       <= '0;
            ptr_reg       <= '0;
            addr_hold_reg <= '0;
            data_hold_reg <= '0;
            adr_reg       <= '0;
            dat_reg       <= '0;
        end else begin
            case (state_reg)
                OMEMSEQ_IDLE: begin
                    if (grant_valid) begin
                        addr_hold_reg <= sel_addr;
                        data_hold_reg <= sel_data;
                        idx_reg       <= grant_idx;
                        ptr_reg       <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                             : grant_idx + IDX_W'(1);
                        beat_reg      <= BEAT_HI;
                        cnt_reg       <= '0;
                        err_reg       <= 1'b0;
                        first_reg     <= 1'b1;
                        adr_reg       <= word_mux3(BEAT_HI, sel_addr);
                        dat_reg       <= word_mux3(BEAT_HI, sel_data);
                    end
                end
                OMEMSEQ_BEAT: begin
                    first_reg <= 1'b0;
                    if (ACK_I) begin
                        cnt_reg <= '0;
                        if (beat_reg != BEAT_LO) begin
                            beat_reg <= beat_next;
                            adr_reg  <= word_mux3(beat_next, addr_hold_reg);
                            dat_reg  <= word_mux3(beat_next, data_hold_reg);
                        end
                    end else if (timeout_hit) begin
                        err_reg <= 1'b1;
                    end else if (ACK_TIMEOUT != 0) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    beat_reg  <= BEAT_HI;
                    first_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        oAccept = '0;
        oDone   = '0;
        oError  = '0;
        oIdle   = (state_reg == OMEMSEQ_IDLE);
        CYC_O   = (state_reg == OMEMSEQ_BEAT);
        STB_O   = (state_reg == OMEMSEQ_BEAT);
        WE_O    = (state_reg == OMEMSEQ_BEAT);
        if (state_reg == OMEMSEQ_BEAT && first_reg) begin
            oAccept[idx_reg] = 1'b1;
        end
        if (state_reg == OMEMSEQ_RETIRE) begin
            if (err_reg) begin
                oError[idx_reg] = 1'b1;
            end else begin
                oDone[idx_reg] = 1'b1;
            end
        end
    end

    assign ADR_O = adr_reg;
    assign DAT_O = dat_reg;

endmodule

// File: tb/tb_omem_write_sequencer.sv
// Bench for omem_write_sequencer: table of single bursts plus hand-written round-robin
// and mid-burst reset sequences, with beat/accept/retire scoreboards.
module tb_omem_write_sequencer;

    localparam int NR = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*96-1:0]  idata, iaddr;
    logic [NR-1:0]     acc, done, err;
    logic              idle;
    logic [31:0]       adr, dat;
    logic              we, stb, cyc, ack;

    omem_write_sequencer #(.NUM_REQ(NR), .ACK_TIMEOUT(TO)) dut (
        .Clock(clk), .Reset(rst_n), .iRequest(req), .iData(idata), .iAddress(iaddr),
        .oAccept(acc), .oDone(done), .oError(err), .oIdle(idle),
        .ADR_O(adr), .DAT_O(dat), .WE_O(we), .STB_O(stb), .CYC_O(cyc), .ACK_I(ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed { logic [31:0] a; logic [31:0] d; } beat_t;
    typedef struct { bit is_err; int r; } ev_t;
    beat_t exp_beats[$];
    int    exp_acc[$];
    ev_t   exp_ev[$];

    // Wishbone slave: per-beat wait states, or never acknowledge a chosen beat.
    int waits[3];
    bit no_ack[3];
    int slv_beat, slv_wait;
    initial begin
        ack = 1'b0; slv_beat = 0; slv_wait = 0;
        forever begin
            tick();
            if (!stb) begin
                slv_beat = 0; slv_wait = 0; ack = 1'b0;
            end else begin
                if (ack) begin slv_beat++; slv_wait = 0; end
                ack = (slv_beat < 3) && !no_ack[slv_beat] && (slv_wait >= waits[slv_beat]);
                slv_wait++;
            end
        end
    end

    // Monitor: scoreboard pops and beat stability, sampled mid-cycle.
    logic [31:0] prev_adr, prev_dat;
    logic prev_stb = 1'b0, prev_ack = 1'b0;
    always @(negedge clk) begin
        beat_t b;
        ev_t e;
        logic [NR-1:0] oh;
        if (rst_n) begin
            if (stb && prev_stb && !prev_ack) begin
                check("adr_stable", adr, prev_adr);
                check("dat_stable", dat, prev_dat);
            end
            if (stb && ack) begin
                if (exp_beats.size() == 0) check("beat_unexpected", {adr, dat}, 0);
                else begin
                    b = exp_beats.pop_front();
                    check("beat_adr", adr, b.a);
                    check("beat_dat", dat, b.d);
                end
            end
            if (acc != 0) begin
                if (exp_acc.size() == 0) check("accept_unexpected", acc, 0);
                else begin
                    oh = '0; oh[exp_acc.pop_front()] = 1'b1;
                    check("accept_vec", acc, oh);
                end
            end
            if ((done | err) != 0) begin
                if (exp_ev.size() == 0) check("retire_unexpected", {done, err}, 0);
                else begin
                    e = exp_ev.pop_front();
                    oh = '0; oh[e.r] = 1'b1;
                    check("done_vec", done, e.is_err ? '0 : oh);
                    check("error_vec", err, e.is_err ? oh : '0);
                end
            end
        end
        prev_stb = stb; prev_ack = ack; prev_adr = adr; prev_dat = dat;
    end

    task automatic push_beats(input logic [95:0] a, input logic [95:0] d, input int n);
        for (int b = 0; b < n; b++) begin
            exp_beats.push_back({a[95-32*b -: 32], d[95-32*b -: 32]});
        end
    endtask

    task automatic set_waits(input int w0, input int w1, input int w2, input int nab);
        waits[0] = w0; waits[1] = w1; waits[2] = w2;
        for (int b = 0; b < 3; b++) no_ack[b] = (b == nab);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!idle && n < 50) begin tick(); n++; end
        check("idle_reached", idle, 1);
    endtask

    task automatic wait_ev_drain(input string name);
        int n = 0;
        while (exp_ev.size() != 0 && n < 60) begin tick(); n++; end
        check(name, exp_ev.size(), 0);
    endtask

    typedef struct {
        int r; logic [95:0] a; logic [95:0] d;
        int w0; int w1; int w2; int nab; bit is_err; int lat;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [95:0] addr_of(input int k);
        return {32'(k * 16 + 1), 32'(k * 16 + 2), 32'(k * 16 + 3)};
    endfunction
    function automatic logic [95:0] data_of(input int k);
        return {32'hD000_0000 + 32'(k), 32'hE000_0000 + 32'(k), 32'hF000_0000 + 32'(k)};
    endfunction

    initial begin
        int order[5];
        int naccept, cyc_n, low_run, lat, n;
        bit seen_high;
        vec_t v;

        vecs[0] = '{0, 96'h000000AA_000000BB_000000CC, 96'h11111111_22222222_33333333, 0, 0, 0, -1, 0, 3};
        vecs[1] = '{1, 96'h00001000_00001004_00001008, 96'hCAFEF00D_DEADBEEF_0BADC0DE, 0, 3, 0, -1, 0, 6};
        vecs[2] = '{3, 96'h00002000_00002004_00002008, 96'hA5A5A5A5_5A5A5A5A_FFFF0000, 0, 0, 0, 2, 1, 10};
        vecs[3] = '{2, 96'h00003000_00003004_00003008, 96'h01234567_89ABCDEF_76543210, 2, 0, 1, -1, 0, 6};
        vecs[4] = '{0, 96'h00004000_00004004_00004008, 96'h0F0F0F0F_F0F0F0F0_33CC33CC, 0, 0, 0, 0, 1, 8};

        rst_n = 1'b0; req = '0; idata = '0; iaddr = '0;
        set_waits(0, 0, 0, -1);
        repeat (3) tick();
        check("reset_ctrl", {cyc, stb, we, acc, done, err, idle}, 16'h0001);
        check("reset_adr", adr, 0);
        check("reset_dat", dat, 0);
        rst_n = 1'b1;
        tick();

        // All four requests held: grants 0,1,2,3,0 with a 2-cycle CYC_O gap.
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            exp_acc.push_back(order[i]);
            push_beats(addr_of(order[i]), data_of(order[i]), 3);
            exp_ev.push_back('{0, order[i]});
        end
        for (int k = 0; k < NR; k++) begin
            iaddr[k*96 +: 96] = addr_of(k);
            idata[k*96 +: 96] = data_of(k);
        end
        req = '1;
        naccept = 0; cyc_n = 0; low_run = 0; seen_high = 0;
        while (naccept < 5 && cyc_n < 60) begin
            tick(); cyc_n++;
            if (acc != 0) naccept++;
            if (!cyc) low_run++;
            else begin
                if (seen_high && low_run > 0) check("rr_cyc_gap", low_run, 2);
                low_run = 0; seen_high = 1;
            end
        end
        req = '0;
        check("rr_accepts", naccept, 5);
        wait_ev_drain("rr_drain");

        // Single bursts from the table.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            wait_idle();
            set_waits(v.w0, v.w1, v.w2, v.nab);
            push_beats(v.a, v.d, (v.nab < 0) ? 3 : v.nab);
            exp_acc.push_back(v.r);
            exp_ev.push_back('{v.is_err, v.r});
            iaddr[v.r*96 +: 96] = v.a;
            idata[v.r*96 +: 96] = v.d;
            req[v.r] = 1'b1;
            n = 0;
            do begin tick(); n++; end while (!acc[v.r] && n < 20);
            check($sformatf("grant_latency_%0d", i), n, 1);
            req[v.r] = 1'b0;
            iaddr[v.r*96 +: 96] = ~v.a;
            idata[v.r*96 +: 96] = ~v.d;
            lat = 0;
            do begin tick(); lat++; end while ((done | err) == 0 && lat < 40);
            check($sformatf("retire_latency_%0d", i), lat, v.lat);
            check($sformatf("retire_kind_%0d", i), {done[v.r], err[v.r]}, v.is_err ? 2'b01 : 2'b10);
            tick();
        end

        // Reset during beat 010, then pointer restarts at 0.
        wait_idle();
        set_waits(0, 5, 0, -1);
        iaddr[96 +: 96] = addr_of(5);
        idata[96 +: 96] = data_of(5);
        push_beats(addr_of(5), data_of(5), 1);
        exp_acc.push_back(1);
        req[1] = 1'b1;
        tick();
        check("mid_accept", acc, 4'b0010);
        req[1] = 1'b0;
        tick();
        check("mid_beat_adr", adr, 32'(5 * 16 + 2));
        rst_n = 1'b0;
        tick();
        check("midrst_ctrl", {cyc, stb, we, acc, done, err, idle}, 16'h0001);
        check("midrst_adr", adr, 0);
        check("midrst_dat", dat, 0);
        rst_n = 1'b1;
        set_waits(0, 0, 0, -1);
        iaddr[96 +: 96] = addr_of(6);
        idata[96 +: 96] = data_of(6);
        iaddr[3*96 +: 96] = addr_of(7);
        idata[3*96 +: 96] = data_of(7);
        exp_acc.push_back(1);
        push_beats(addr_of(6), data_of(6), 3);
        exp_ev.push_back('{0, 1});
        req = 4'b1010;
        tick();
        check("post_reset_grant", acc, 4'b0010);
        req = '0;
        wait_ev_drain("post_reset_drain");

        repeat (3) tick();
        check("beats_left", exp_beats.size(), 0);
        check("accepts_left", exp_acc.size(), 0);
        check("events_left", exp_ev.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
